// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control inputs from the sequencing FSM and the
// registered select lines / scan status returned to it.
interface scan_decoder_if #(
  parameter int ADDR_WIDTH = 2
);
  localparam int OUTS = 1 << ADDR_WIDTH;

  logic                  enable;
  logic [ADDR_WIDTH-1:0] address;
  logic                  mode;
  logic                  scan_start;
  logic [OUTS-1:0]       out;
  logic                  scan_busy;
  logic                  scan_done;
  logic [ADDR_WIDTH-1:0] scan_index;

  modport master (
    output enable, address, mode, scan_start,
    input  out, scan_busy, scan_done, scan_index
  );

  modport slave (
    input  enable, address, mode, scan_start,
    output out, scan_busy, scan_done, scan_index
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct mode (out follows address) and a
// scan mode that walks a single asserted line across all outputs, holding
// each one for SCAN_DWELL asserted cycles. Dropping enable pauses the scan;
// the dwell counter counts only cycles in which the line was really asserted,
// so every paused cycle lengthens the scan by exactly one cycle.
module scan_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int SCAN_DWELL = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  scan_decoder_if.slave  bus
);
  localparam int OUTS = 1 << ADDR_WIDTH;
  localparam int DW   = $clog2(SCAN_DWELL + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state_q, state_d;
  logic [OUTS-1:0]       out_q, out_d;
  logic [OUTS-1:0]       direct_sel;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic [DW-1:0]         served;

  // Next-state, next-output and scan position/dwell bookkeeping.
  always_comb begin
    state_d    = state_q;
    out_d      = '0;
    idx_d      = idx_q;
    dwell_d    = dwell_q;
    direct_sel = bus.enable ? (OUTS'(1) << bus.address) : '0;
    // Asserted cycles completed for the current position, including the one
    // that ends at this edge (a paused cycle shows nothing and does not count).
    served     = dwell_q + DW'(|out_q);

    case (state_q)
      IDLE: begin
        idx_d   = '0;
        dwell_d = '0;
        if (!bus.mode) begin
          out_d = direct_sel;
        end else if (bus.scan_start) begin
          state_d = SCAN;
          out_d   = bus.enable ? OUTS'(1) : '0;
        end
      end

      SCAN: begin
        if (!bus.mode) begin
          // Abort: fall straight back to direct decoding, no done pulse.
          state_d = IDLE;
          idx_d   = '0;
          dwell_d = '0;
          out_d   = direct_sel;
        end else begin
          dwell_d = served;
          if (served == DW'(SCAN_DWELL)) begin
            dwell_d = '0;
            if (idx_q == ADDR_WIDTH'(OUTS - 1)) begin
              state_d = DONE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          // Old bit drops and new bit rises on the same edge.
          if (state_d == SCAN && bus.enable) begin
            out_d = OUTS'(1) << idx_d;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        dwell_d = '0;
      end
    endcase
  end

  // State, select lines, scan position and dwell registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.scan_busy  = (state_q == SCAN);
  assign bus.scan_done  = (state_q == DONE);
  assign bus.scan_index = idx_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: a 4-output instance (dwell 1) and an 8-output
// instance (dwell 2) sharing clock and reset.
module tb_scan_decoder;
  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   viol   = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.ADDR_WIDTH(2)) if2 ();
  scan_decoder_if #(.ADDR_WIDTH(3)) if3 ();

  scan_decoder #(.ADDR_WIDTH(2), .SCAN_DWELL(1)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2)
  );
  scan_decoder #(.ADDR_WIDTH(3), .SCAN_DWELL(2)) u3 (
    .clk(clk), .reset_n(reset_n), .bus(if3)
  );

  typedef struct {
    logic       en;
    logic [1:0] addr;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Structural invariants watched on every falling edge once out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (!$onehot0(if2.out) || !$onehot0(if3.out) ||
          (if2.scan_busy && if2.scan_done) || (if3.scan_busy && if3.scan_done))
        viol++;
    end
  end

  initial begin
    int done_cnt;
    int done_at;

    vecs[0] = '{1'b0, 2'd0, 4'b0000};
    vecs[1] = '{1'b0, 2'd1, 4'b0000};
    vecs[2] = '{1'b0, 2'd2, 4'b0000};
    vecs[3] = '{1'b0, 2'd3, 4'b0000};
    vecs[4] = '{1'b1, 2'd0, 4'b0001};
    vecs[5] = '{1'b1, 2'd1, 4'b0010};
    vecs[6] = '{1'b1, 2'd2, 4'b0100};
    vecs[7] = '{1'b1, 2'd3, 4'b1000};

    // Reset with scan_start and mode=1 held high: must have no effect.
    reset_n = 1'b0;
    if2.enable = 1'b1; if2.address = '0; if2.mode = 1'b1; if2.scan_start = 1'b1;
    if3.enable = 1'b1; if3.address = '0; if3.mode = 1'b1; if3.scan_start = 1'b1;
    step();
    step();
    chk("reset_out2",  if2.out, 0);
    chk("reset_busy2", if2.scan_busy, 0);
    chk("reset_done2", if2.scan_done, 0);
    chk("reset_idx2",  if2.scan_index, 0);
    chk("reset_out3",  if3.out, 0);
    reset_n = 1'b1;
    if2.scan_start = 1'b0; if3.scan_start = 1'b0;
    if3.enable = 1'b0;
    step();
    chk("post_reset_busy2", if2.scan_busy, 0);
    chk("post_reset_out2",  if2.out, 0);

    // Direct sweep on the 4-output instance.
    if2.mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if2.enable  = vecs[i].en;
      if2.address = vecs[i].addr;
      step();
      chk($sformatf("direct_en%0d_a%0d", vecs[i].en, vecs[i].addr), if2.out, vecs[i].exp_out);
    end

    // Full scan on the 8-output instance, dwell 2.
    if3.mode = 1'b1; if3.enable = 1'b1; if3.scan_start = 1'b1;
    step();
    if3.scan_start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      chk($sformatf("scan3_out_c%0d", c), if3.out, 32'(8'd1 << (c / 2)));
      chk($sformatf("scan3_idx_c%0d", c), if3.scan_index, c / 2);
      chk($sformatf("scan3_busy_c%0d", c), {if3.scan_busy, if3.scan_done}, 2'b10);
      step();
    end
    chk("scan3_done_pulse", {if3.scan_busy, if3.scan_done}, 2'b01);
    chk("scan3_done_out",   if3.out, 0);
    chk("scan3_done_idx",   if3.scan_index, 0);
    step();
    chk("scan3_after_done", {if3.scan_busy, if3.scan_done}, 2'b00);
    if3.enable = 1'b0;

    // Pause while on position 2 (4 outputs, dwell 1): 8 edges start to done.
    if2.mode = 1'b1; if2.enable = 1'b1; if2.scan_start = 1'b1;
    step();                                   // edge 1
    if2.scan_start = 1'b0;
    chk("pause_start_out", if2.out, 4'b0001);
    chk("pause_start_busy", if2.scan_busy, 1);
    step();                                   // edge 2
    chk("pause_pos1_out", if2.out, 4'b0010);
    if2.enable = 1'b0;
    for (int p = 0; p < 3; p++) begin         // edges 3..5
      step();
      chk($sformatf("pause_hold_out_%0d", p), if2.out, 0);
      chk($sformatf("pause_hold_idx_%0d", p), if2.scan_index, 2);
      chk($sformatf("pause_hold_busy_%0d", p), if2.scan_busy, 1);
    end
    if2.enable = 1'b1;
    step();                                   // edge 6
    chk("resume_out_pos2", if2.out, 4'b0100);
    step();                                   // edge 7
    chk("resume_out_pos3", if2.out, 4'b1000);
    chk("resume_done_not_yet", if2.scan_done, 0);
    step();                                   // edge 8
    chk("pause_done_edge8", {if2.scan_busy, if2.scan_done, if2.out}, 6'b01_0000);
    step();

    // Abort at position 1: direct rule applies on the same edge.
    if2.scan_start = 1'b1;
    step();
    if2.scan_start = 1'b0;
    step();
    chk("abort_pre_idx", if2.scan_index, 1);
    if2.mode = 1'b0; if2.address = 2'd3; if2.enable = 1'b1;
    step();
    chk("abort_out",  if2.out, 4'b1000);
    chk("abort_busy", if2.scan_busy, 0);
    chk("abort_idx",  if2.scan_index, 0);
    done_cnt = (if2.scan_done === 1'b1) ? 1 : 0;
    for (int w = 0; w < 6; w++) begin
      step();
      if (if2.scan_done !== 1'b0) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    // Reset mid-scan at position 2, with scan_start held during reset.
    if2.mode = 1'b1; if2.scan_start = 1'b1;
    step();
    if2.scan_start = 1'b0;
    step();
    step();
    chk("rst_mid_pre_idx", if2.scan_index, 2);
    reset_n = 1'b0; if2.scan_start = 1'b1;
    step();
    chk("rst_mid_out",  if2.out, 0);
    chk("rst_mid_busy", if2.scan_busy, 0);
    chk("rst_mid_idx",  if2.scan_index, 0);
    reset_n = 1'b1; if2.scan_start = 1'b0;
    step();
    chk("rst_mid_no_start", {if2.scan_busy, if2.out}, 5'b0_0000);

    // Restart requests during SCAN and during DONE are ignored.
    if2.scan_start = 1'b1;
    step();                                   // start edge (j = 0)
    if2.scan_start = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    for (int j = 1; j <= 8; j++) begin
      if (j == 2 || j == 5) if2.scan_start = 1'b1;
      step();
      if2.scan_start = 1'b0;
      if (if2.scan_done === 1'b1) begin
        done_cnt++;
        done_at = j;
      end
      if (j == 5) chk("restart_in_done_ignored", if2.scan_busy, 0);
    end
    chk("restart_single_done", done_cnt, 1);
    chk("restart_done_cycle",  done_at, 4);

    chk("invariants", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
